// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the MIPS pipeline control path: FSM encoding,
// the IF/ID flush instruction and the hard-wired zero register index.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } ctrl_state_e;

  // sll $0,$0,0 -- the canonical MIPS NOP loaded into IF/ID on flush
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int ZERO_REG = 0;

endpackage

// File: rtl/hazard_unit.sv
// Load-use detector: a load in EX whose destination feeds either source
// of the instruction in decode. Writes to $zero never create a hazard.
module hazard_unit
  import mips_ctrl_pkg::*;
#(
  parameter int NB = 5
) (
  input  logic          mem_read,
  input  logic [NB-1:0] ex_rt,
  input  logic [NB-1:0] id_rs,
  input  logic [NB-1:0] id_rt,
  output logic          load_use
);

  assign load_use = mem_read && (ex_rt != NB'(ZERO_REG)) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: stage enables, IF/ID flush and ID/EX bubble, plus the
// run/step/drain/done lifecycle. Define PIPE_CTRL_CYCLE_COUNT_EN for the counter.
module pipeline_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int NB           = 5,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_run,
  input  logic          cmd_step,
  input  logic          halt_decoded,
  input  logic [NB-1:0] id_rs,
  input  logic [NB-1:0] id_rt,
  input  logic          flag_jump,
  input  logic          flag_jump_register,
  input  logic          ex_mem_read,
  input  logic [NB-1:0] ex_rt,
  input  logic          ex_branch_taken,
  output logic          pc_en,
  output logic          ifid_en,
  output logic          pipe_en,
  output logic          ifid_flush,
  output logic          idex_bubble,
  output logic [2:0]    state,
  output logic          step_done,
  output logic          halted,
  output logic [31:0]   cycle_count
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  ctrl_state_e   state_q, state_n;
  logic [CW-1:0] drain_cnt;
  logic          load_use, active, halt_go, step_done_q;

  hazard_unit #(.NB(NB)) u_hazard (
    .mem_read (ex_mem_read),
    .ex_rt    (ex_rt),
    .id_rs    (id_rs),
    .id_rt    (id_rt),
    .load_use (load_use)
  );

  assign active  = (state_q == ST_RUN) || (state_q == ST_STEP);
  // A stalled or squashed HALT has not really committed to leaving decode
  assign halt_go = halt_decoded && !load_use && !ex_branch_taken;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE:  if (cmd_run) state_n = ST_RUN;
                else if (cmd_step) state_n = ST_STEP;
      ST_RUN:   if (halt_go) state_n = ST_DRAIN;
      ST_STEP:  state_n = halt_go ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: if (drain_cnt == '0) state_n = ST_DONE;
      ST_DONE:  state_n = ST_DONE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    pipe_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (active) begin
      pipe_en = 1'b1;
      if (ex_branch_taken) begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (load_use) begin
        idex_bubble = 1'b1;
      end else begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = flag_jump || flag_jump_register;
      end
    end else if (state_q == ST_DRAIN) begin
      pipe_en    = 1'b1;
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drain_cnt   <= '0;
      step_done_q <= 1'b0;
    end else begin
      if (active && halt_go)
        drain_cnt <= CW'(DRAIN_CYCLES - 1);
      else if (state_q == ST_DRAIN && drain_cnt != '0)
        drain_cnt <= drain_cnt - 1'b1;
      step_done_q <= (state_q == ST_STEP) && (state_n == ST_IDLE);
    end
  end

  assign state     = state_q;
  assign step_done = step_done_q;
  assign halted    = (state_q == ST_DONE);

`ifdef PIPE_CTRL_CYCLE_COUNT_EN
  logic [31:0] cnt_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       cnt_q <= '0;
    else if (pipe_en) cnt_q <= cnt_q + 32'd1;
  end
  assign cycle_count = cnt_q;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized bench for pipeline_ctrl: a driver pushes model predictions into
// a queue, and an independent monitor pops and compares them every cycle.
module tb_pipeline_ctrl;

  localparam int NB = 5;
  localparam int DC = 4;

  typedef struct packed {
    logic        pc, ifid, pipe, flush, bub;
    logic [2:0]  st;
    logic        sd, h;
    logic [31:0] cnt;
  } obs_t;

  logic clk = 1'b0, reset = 1'b0;
  logic cmd_run, cmd_step, halt_decoded, flag_jump, flag_jump_register;
  logic ex_mem_read, ex_branch_taken;
  logic [NB-1:0] id_rs, id_rt, ex_rt;
  logic pc_en, ifid_en, pipe_en, ifid_flush, idex_bubble, step_done, halted;
  logic [2:0]  state;
  logic [31:0] cycle_count;

  always #5 clk = ~clk;

  pipeline_ctrl #(.NB(NB), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .cmd_run(cmd_run), .cmd_step(cmd_step),
    .halt_decoded(halt_decoded), .id_rs(id_rs), .id_rt(id_rt),
    .flag_jump(flag_jump), .flag_jump_register(flag_jump_register),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .pc_en(pc_en), .ifid_en(ifid_en), .pipe_en(pipe_en), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .state(state), .step_done(step_done),
    .halted(halted), .cycle_count(cycle_count)
  );

  obs_t exp_q[$];
  obs_t mon_e;
  int   vectors = 0, miscompares = 0, cyc = 0;

  // reference model: mode 0 idle, 1 run, 2 step, 3 drain, 4 done
  int          m_mode = 0, m_left = 0, done_cycles = 0;
  bit          m_sd = 0;
  logic [31:0] m_cnt = 0;

  function automatic string fmt(obs_t o);
    return $sformatf("pc=%0b ifid=%0b pipe=%0b flush=%0b bub=%0b st=%0d sd=%0b h=%0b cnt=%0d",
                     o.pc, o.ifid, o.pipe, o.flush, o.bub, o.st, o.sd, o.h, o.cnt);
  endfunction

  function automatic obs_t actual();
    obs_t o;
    o.pc = pc_en; o.ifid = ifid_en; o.pipe = pipe_en; o.flush = ifid_flush;
    o.bub = idex_bubble; o.st = state; o.sd = step_done; o.h = halted;
    o.cnt = cycle_count;
    return o;
  endfunction

  task automatic check(string name, obs_t e);
    obs_t g;
    g = actual();
    vectors++;
    if (g !== e) begin
      miscompares++;
      $display("FAIL %s: got {%s} expected {%s}", name, fmt(g), fmt(e));
    end
  endtask

  function automatic bit hazard();
    return ex_mem_read && (ex_rt != 0) && (ex_rt == id_rs || ex_rt == id_rt);
  endfunction

  function automatic obs_t model_out();
    obs_t o;
    o = '0;
    o.st = 3'(m_mode);
    o.sd = m_sd;
    o.h  = (m_mode == 4);
`ifdef PIPE_CTRL_CYCLE_COUNT_EN
    o.cnt = m_cnt;
`endif
    if (m_mode == 1 || m_mode == 2) begin
      o.pipe = 1;
      if (ex_branch_taken) {o.pc, o.ifid, o.flush, o.bub} = 4'b1111;
      else if (hazard())   o.bub = 1;
      else begin
        o.pc = 1; o.ifid = 1; o.flush = flag_jump | flag_jump_register;
      end
    end else if (m_mode == 3) begin
      o.pipe = 1; o.flush = 1;
    end
    return o;
  endfunction

  task automatic model_advance();
    int nxt;
    bit go;
    nxt = m_mode;
    go  = halt_decoded && !hazard() && !ex_branch_taken;
    if (m_mode >= 1 && m_mode <= 3) m_cnt = m_cnt + 1;
    m_sd = 0;
    case (m_mode)
      0: nxt = cmd_run ? 1 : (cmd_step ? 2 : 0);
      1: if (go) begin nxt = 3; m_left = DC; end
      2: if (go) begin nxt = 3; m_left = DC; end
         else begin nxt = 0; m_sd = 1; end
      3: begin m_left--; if (m_left == 0) nxt = 4; end
      default: ;
    endcase
    done_cycles = (m_mode == 4) ? done_cycles + 1 : 0;
    m_mode = nxt;
  endtask

  task automatic clear_inputs();
    {cmd_run, cmd_step, halt_decoded, flag_jump, flag_jump_register} = '0;
    {ex_mem_read, ex_branch_taken} = '0;
    id_rs = '0; id_rt = '0; ex_rt = '0;
  endtask

  task automatic apply_reset(string name);
    reset = 1'b0;
    clear_inputs();
    #1;
    check(name, '0);
    m_mode = 0; m_left = 0; m_sd = 0; m_cnt = 0; done_cycles = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check($sformatf("cycle %0d", cyc), mon_e);
      end
    end
  end

  initial begin
    bit want_rst;
    clear_inputs();
    @(negedge clk);
    check("reset values", '0);
    reset = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      cyc = i;
      want_rst = (m_mode == 4 && done_cycles >= 3) ||
                 (m_mode == 3 && m_left == DC - 1 && $urandom_range(0, 1) == 1) ||
                 ($urandom_range(0, 399) == 0);
      if (want_rst) begin
        apply_reset($sformatf("async reset cycle %0d", i));
        continue;
      end
      cmd_run            = ($urandom_range(0, 7) == 0);
      cmd_step           = ($urandom_range(0, 4) == 0);
      halt_decoded       = ($urandom_range(0, 24) == 0);
      id_rs              = NB'($urandom_range(0, 3));
      id_rt              = NB'($urandom_range(0, 3));
      ex_rt              = NB'($urandom_range(0, 3));
      ex_mem_read        = ($urandom_range(0, 2) == 0);
      ex_branch_taken    = ($urandom_range(0, 9) == 0);
      flag_jump          = ($urandom_range(0, 9) == 0);
      flag_jump_register = ($urandom_range(0, 11) == 0);
      exp_q.push_back(model_out());
      model_advance();
    end
    @(posedge clk);
    #1;
    clear_inputs();
    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
